// File: rtl/entry_pkg.sv
// Shared types and widths for the operand entry front end.
package entry_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int NIB_W  = 4;
    localparam int WORD_W = 16;

endpackage

// File: rtl/btn_debounce.sv
// Counter-based debouncer for an already-synchronized active-low key,
// with a one-cycle strobe on each debounced press (1->0).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic clear,
    input  logic in_sync,
    output logic db_out,
    output logic fall_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // The debounced value only moves after DEBOUNCE_CYCLES disagreeing
    // samples in a row; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            cnt        <= '0;
            db_out     <= 1'b1;
            fall_pulse <= 1'b0;
        end else begin
            fall_pulse <= 1'b0;
            if (in_sync == db_out) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                cnt        <= '0;
                db_out     <= in_sync;
                fall_pulse <= db_out & ~in_sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Input front end: synchronizes the keys/switches, debounces `next` and packs
// nibbles into a word offered over valid/ready. Optional ENTRY_LONGPRESS_CLR_EN.
module operand_entry
    import entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int NIBBLES         = 4,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              next,
    input  logic [NIB_W-1:0]  Din,
    input  logic              level,
    input  logic              word_ready,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              level_sync,
    output logic [NIB_W-1:0]  din_sync,
    output logic [1:0]        nib_count,
    output logic              next_pulse
);

    localparam logic [1:0] LAST_NIB = 2'(NIBBLES - 1);

    state_t            state;
    logic              next_s1, next_sync;
    logic [NIB_W-1:0]  din_s1;
    logic              level_s1;
    logic              next_db;
    logic              lp_fire;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            next_s1    <= 1'b1;
            next_sync  <= 1'b1;
            din_s1     <= '0;
            din_sync   <= '0;
            level_s1   <= 1'b0;
            level_sync <= 1'b0;
        end else begin
            next_s1    <= next;
            next_sync  <= next_s1;
            din_s1     <= Din;
            din_sync   <= din_s1;
            level_s1   <= level;
            level_sync <= level_s1;
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_next_db (
        .clk       (clk),
        .clear     (clear),
        .in_sync   (next_sync),
        .db_out    (next_db),
        .fall_pulse(next_pulse)
    );

`ifdef ENTRY_LONGPRESS_CLR_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);

    logic [LW-1:0] lp_cnt;

    // Saturates so the clear fires exactly once per hold of the key.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            lp_cnt <= '0;
        end else if (next_db) begin
            lp_cnt <= '0;
        end else if (lp_cnt != LW'(LONG_CYCLES)) begin
            lp_cnt <= lp_cnt + 1'b1;
        end
    end

    assign lp_fire = ~next_db && (lp_cnt == LW'(LONG_CYCLES - 1));
`else
    assign lp_fire = 1'b0;
`endif

    // In HOLD the word is frozen and presses are dropped, including one
    // that lands in the same cycle as the accepting handshake.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state      <= COLLECT;
            word_valid <= 1'b0;
            word_data  <= '0;
            nib_count  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (lp_fire) begin
                        word_data <= '0;
                        nib_count <= '0;
                    end else if (next_pulse) begin
                        word_data <= {word_data[WORD_W-NIB_W-1:0], din_sync};
                        if (nib_count == LAST_NIB) begin
                            nib_count  <= '0;
                            word_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            nib_count <= nib_count + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        word_data  <= '0;
                        state      <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule
